// File: rtl/iq_seq_pkg.sv
// Shared constants for the I/Q frame sequencer: FSM encodings, timeout class code
// and default frame geometry.
package iq_seq_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FEED     = 3'd1;
  localparam logic [2:0] ST_DRAIN    = 3'd2;
  localparam logic [2:0] ST_WAIT_RES = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  localparam logic [7:0] CLASS_TIMEOUT = 8'hFF;

  localparam int DEF_FRAME_LEN  = 128;
  localparam int DEF_NUM_FRAMES = 16;
  localparam int DEF_RD_LAT     = 1;

endpackage

// File: rtl/iq_frame_sequencer_rd_lat_pipe.sv
// Delay line for a memory read strobe plus the capture register for the returning
// data, so the output strobe lines up with the registered samples.
module rd_lat_pipe #(
  parameter int LAT = 1,
  parameter int W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         issue,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         out_valid,
  output logic         pending
);

  logic [LAT-1:0] sh;

  assign pending = |sh;

  // The tail of the shift register marks the cycle in which memory data is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh        <= '0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else begin
      sh[0] <= issue;
      for (int i = 1; i < LAT; i++) sh[i] <= sh[i-1];
      out_valid <= sh[LAT-1];
      if (sh[LAT-1]) begin
        out_a <= in_a;
        out_b <= in_b;
      end
    end
  end

endmodule

// File: rtl/iq_frame_sequencer.sv
// Feeds consecutive FRAME_LEN-sample I/Q frames from the sample memories into the
// classifier and reports one result (or a timeout) per frame.
module iq_frame_sequencer
  import iq_seq_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int NUM_FRAMES = DEF_NUM_FRAMES,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int TIMEOUT    = 65535,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_i,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] din_q,
  output logic              din_valid,
  input  logic              classify_result_vld,
  input  logic [7:0]        classify_result,
  output logic              res_valid,
  output logic [FW-1:0]     res_frame,
  output logic [7:0]        res_class,
  output logic              res_timeout,
  output logic              spurious
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    state;
  logic [CW-1:0] smp_cnt;
  logic [FW-1:0] frame;
  logic [TW-1:0] wait_cnt;
  logic          pipe_pending;
  logic          last_frame;

  assign mem_en     = (state == ST_FEED);
  assign busy       = (state == ST_FEED) || (state == ST_DRAIN) || (state == ST_WAIT_RES);
  assign done       = (state == ST_DONE);
  assign last_frame = (frame == FW'(NUM_FRAMES - 1));

  rd_lat_pipe #(
    .LAT (RD_LAT),
    .W   (DATA_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .issue     (mem_en),
    .in_a      (mem_i),
    .in_b      (mem_q),
    .out_a     (din_i),
    .out_b     (din_q),
    .out_valid (din_valid),
    .pending   (pipe_pending)
  );

  // The cycle res_valid is high doubles as the report cycle; the next frame's
  // first address follows it, so the transition out of WAIT_RES keys off res_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      smp_cnt     <= '0;
      frame       <= '0;
      wait_cnt    <= '0;
      mem_addr    <= '0;
      res_valid   <= 1'b0;
      res_frame   <= '0;
      res_class   <= '0;
      res_timeout <= 1'b0;
      spurious    <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (classify_result_vld && (state != ST_WAIT_RES)) spurious <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FEED;
            smp_cnt  <= '0;
            frame    <= '0;
            mem_addr <= '0;
            spurious <= 1'b0;
          end
        end
        ST_FEED: begin
          mem_addr <= mem_addr + ADDR_W'(1);
          smp_cnt  <= smp_cnt + CW'(1);
          if (smp_cnt == CW'(FRAME_LEN - 1)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!pipe_pending) begin
            state    <= ST_WAIT_RES;
            wait_cnt <= '0;
          end
        end
        ST_WAIT_RES: begin
          if (res_valid) begin
            if (last_frame) begin
              state <= ST_DONE;
            end else begin
              frame <= frame + FW'(1);
              state <= ST_FEED;
            end
          end else if (classify_result_vld) begin
            res_valid   <= 1'b1;
            res_frame   <= frame;
            res_class   <= classify_result;
            res_timeout <= 1'b0;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            res_valid   <= 1'b1;
            res_frame   <= frame;
            res_class   <= CLASS_TIMEOUT;
            res_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iq_frame_sequencer.sv
// Directed bench: instance 0 uses RD_LAT=1 with two frames, instance 1 uses RD_LAT=3
// with a full sixteen-frame run; both share a behavioural ROM and TIMEOUT=100.
module tb_iq_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s       [2];
  logic        start_s     [2];
  logic        busy_s      [2];
  logic        done_s      [2];
  logic        mem_en_s    [2];
  logic [10:0] mem_addr_s  [2];
  logic [15:0] mem_i_s     [2];
  logic [15:0] mem_q_s     [2];
  logic [15:0] din_i_s     [2];
  logic [15:0] din_q_s     [2];
  logic        din_valid_s [2];
  logic        vld_s       [2];
  logic [7:0]  cls_s       [2];
  logic        res_valid_s [2];
  logic [3:0]  res_frame_s [2];
  logic [7:0]  res_class_s [2];
  logic        res_tmo_s   [2];
  logic        spurious_s  [2];
  logic [0:0]  res_frame_a;
  logic [3:0]  res_frame_b;

  logic [10:0] addr_a_d1, addr_b_d1, addr_b_d2, addr_b_d3;
  logic        spur_exp [2];
  int          passed = 0;
  int          total  = 0;

  function automatic logic [15:0] rom_i(input logic [10:0] a);
    return {5'b10101, a};
  endfunction

  function automatic logic [15:0] rom_q(input logic [10:0] a);
    return {a, 5'b01101};
  endfunction

  iq_frame_sequencer #(
    .ADDR_W(11), .DATA_W(16), .FRAME_LEN(128), .NUM_FRAMES(2), .RD_LAT(1), .TIMEOUT(100)
  ) u_a (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .mem_en(mem_en_s[0]), .mem_addr(mem_addr_s[0]), .mem_i(mem_i_s[0]), .mem_q(mem_q_s[0]),
    .din_i(din_i_s[0]), .din_q(din_q_s[0]), .din_valid(din_valid_s[0]),
    .classify_result_vld(vld_s[0]), .classify_result(cls_s[0]),
    .res_valid(res_valid_s[0]), .res_frame(res_frame_a), .res_class(res_class_s[0]),
    .res_timeout(res_tmo_s[0]), .spurious(spurious_s[0])
  );

  iq_frame_sequencer #(
    .ADDR_W(11), .DATA_W(16), .FRAME_LEN(128), .NUM_FRAMES(16), .RD_LAT(3), .TIMEOUT(100)
  ) u_b (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .mem_en(mem_en_s[1]), .mem_addr(mem_addr_s[1]), .mem_i(mem_i_s[1]), .mem_q(mem_q_s[1]),
    .din_i(din_i_s[1]), .din_q(din_q_s[1]), .din_valid(din_valid_s[1]),
    .classify_result_vld(vld_s[1]), .classify_result(cls_s[1]),
    .res_valid(res_valid_s[1]), .res_frame(res_frame_b), .res_class(res_class_s[1]),
    .res_timeout(res_tmo_s[1]), .spurious(spurious_s[1])
  );

  always_comb begin
    res_frame_s[0] = {3'b000, res_frame_a};
    res_frame_s[1] = res_frame_b;
    mem_i_s[0]     = rom_i(addr_a_d1);
    mem_q_s[0]     = rom_q(addr_a_d1);
    mem_i_s[1]     = rom_i(addr_b_d3);
    mem_q_s[1]     = rom_q(addr_b_d3);
  end

  // Synchronous ROMs with one and three cycles of read latency.
  always @(posedge clk) begin
    addr_a_d1 <= mem_addr_s[0];
    addr_b_d1 <= mem_addr_s[1];
    addr_b_d2 <= addr_b_d1;
    addr_b_d3 <= addr_b_d2;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Entered on the first address cycle of a frame; returns on the first WAIT_RES cycle.
  task automatic feed_frame(input int u, input int lat, input logic [10:0] base,
                            input int spur_j, input int start_j);
    logic [10:0] ea;
    logic        dv;
    for (int j = 0; j <= lat + 128; j++) begin
      ea = base + 11'(j);
      dv = (j >= lat + 1);
      if (j < 128) begin
        check_output("mem_en_feed", 32'(mem_en_s[u]), 32'd1);
        check_output("mem_addr_feed", 32'(mem_addr_s[u]), 32'(ea));
      end else begin
        check_output("mem_en_drain", 32'(mem_en_s[u]), 32'd0);
      end
      check_output("din_valid", 32'(din_valid_s[u]), 32'(dv));
      if (dv) begin
        ea = base + 11'(j - lat - 1);
        check_output("din_i", 32'(din_i_s[u]), 32'(rom_i(ea)));
        check_output("din_q", 32'(din_q_s[u]), 32'(rom_q(ea)));
      end
      check_output("busy_feed", 32'(busy_s[u]), 32'd1);
      check_output("spurious_feed", 32'(spurious_s[u]), 32'(spur_exp[u]));
      check_output("res_valid_feed", 32'(res_valid_s[u]), 32'd0);
      vld_s[u]   = (j == spur_j);
      start_s[u] = (j == start_j);
      if (j == spur_j) spur_exp[u] = 1'b1;
      tick();
    end
    vld_s[u]   = 1'b0;
    start_s[u] = 1'b0;
  endtask

  // Strobes the result (or lets the timeout expire) on WAIT_RES cycle 'delay',
  // checks the report one cycle later, then steps to the following cycle.
  task automatic wait_result(input int u, input int delay, input bit strobe,
                             input logic [7:0] cls, input int frame, input bit tmo);
    for (int k = 0; k <= delay; k++) begin
      check_output("res_valid_wait", 32'(res_valid_s[u]), 32'd0);
      check_output("busy_wait", 32'(busy_s[u]), 32'd1);
      check_output("mem_en_wait", 32'(mem_en_s[u]), 32'd0);
      check_output("din_valid_wait", 32'(din_valid_s[u]), 32'd0);
      check_output("spurious_wait", 32'(spurious_s[u]), 32'(spur_exp[u]));
      if (k == delay && strobe) begin
        cls_s[u] = cls;
        vld_s[u] = 1'b1;
      end
      tick();
    end
    vld_s[u] = 1'b0;
    check_output("res_valid", 32'(res_valid_s[u]), 32'd1);
    check_output("res_frame", 32'(res_frame_s[u]), 32'(frame));
    check_output("res_class", 32'(res_class_s[u]), 32'(strobe ? cls : 8'hFF));
    check_output("res_timeout", 32'(res_tmo_s[u]), 32'(tmo));
    check_output("spurious_res", 32'(spurious_s[u]), 32'(spur_exp[u]));
    check_output("done_res", 32'(done_s[u]), 32'd0);
    tick();
  endtask

  task automatic end_checks(input int u, input logic [10:0] last_addr);
    check_output("done_pulse", 32'(done_s[u]), 32'd1);
    check_output("busy_at_done", 32'(busy_s[u]), 32'd0);
    check_output("mem_en_at_done", 32'(mem_en_s[u]), 32'd0);
    check_output("mem_addr_at_done", 32'(mem_addr_s[u]), 32'(last_addr));
    check_output("res_valid_at_done", 32'(res_valid_s[u]), 32'd0);
    tick();
    check_output("done_once", 32'(done_s[u]), 32'd0);
    check_output("busy_after_done", 32'(busy_s[u]), 32'd0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_s[u]    = 1'b1;
      start_s[u]  = 1'b0;
      vld_s[u]    = 1'b0;
      cls_s[u]    = 8'h00;
      spur_exp[u] = 1'b0;
    end
    repeat (3) tick();

    for (int u = 0; u < 2; u++) begin
      check_output("rst_busy", 32'(busy_s[u]), 32'd0);
      check_output("rst_done", 32'(done_s[u]), 32'd0);
      check_output("rst_mem_en", 32'(mem_en_s[u]), 32'd0);
      check_output("rst_mem_addr", 32'(mem_addr_s[u]), 32'd0);
      check_output("rst_din_valid", 32'(din_valid_s[u]), 32'd0);
      check_output("rst_din_i", 32'(din_i_s[u]), 32'd0);
      check_output("rst_din_q", 32'(din_q_s[u]), 32'd0);
      check_output("rst_res_valid", 32'(res_valid_s[u]), 32'd0);
      check_output("rst_res_frame", 32'(res_frame_s[u]), 32'd0);
      check_output("rst_res_class", 32'(res_class_s[u]), 32'd0);
      check_output("rst_res_timeout", 32'(res_tmo_s[u]), 32'd0);
      check_output("rst_spurious", 32'(spurious_s[u]), 32'd0);
      rst_s[u] = 1'b0;
    end
    tick();

    // Instance 0: RD_LAT=1, result 8'h03 for frame 0, timeout on frame 1.
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    feed_frame(0, 1, 11'd0, -1, -1);
    wait_result(0, 50, 1'b1, 8'h03, 0, 1'b0);
    feed_frame(0, 1, 11'd128, -1, -1);
    wait_result(0, 99, 1'b0, 8'h00, 1, 1'b1);
    end_checks(0, 11'd256);

    // Instance 1: RD_LAT=3 full run with a spurious strobe and a stray start in frame 0.
    start_s[1] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    feed_frame(1, 3, 11'd0, 10, 20);
    wait_result(1, 99, 1'b0, 8'h00, 0, 1'b1);
    feed_frame(1, 3, 11'd128, -1, -1);
    wait_result(1, 99, 1'b1, 8'h5A, 1, 1'b0);
    for (int f = 2; f < 16; f++) begin
      feed_frame(1, 3, 11'(f * 128), -1, -1);
      wait_result(1, 0, 1'b1, 8'(f + 16), f, 1'b0);
    end
    check_output("spurious_sticky", 32'(spurious_s[1]), 32'd1);
    end_checks(1, 11'd0);

    // Restart clears spurious, then reset at sample 60 flushes the pipeline.
    start_s[1] = 1'b1;
    tick();
    start_s[1]  = 1'b0;
    spur_exp[1] = 1'b0;
    for (int j = 0; j <= 60; j++) begin
      check_output("restart_addr", 32'(mem_addr_s[1]), 32'(j));
      check_output("restart_spurious", 32'(spurious_s[1]), 32'd0);
      if (j == 60) rst_s[1] = 1'b1;
      tick();
    end
    rst_s[1] = 1'b0;
    check_output("midrst_din_valid", 32'(din_valid_s[1]), 32'd0);
    check_output("midrst_mem_en", 32'(mem_en_s[1]), 32'd0);
    check_output("midrst_busy", 32'(busy_s[1]), 32'd0);
    check_output("midrst_mem_addr", 32'(mem_addr_s[1]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_output("flush_din_valid", 32'(din_valid_s[1]), 32'd0);
      check_output("flush_mem_en", 32'(mem_en_s[1]), 32'd0);
    end
    start_s[1] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    check_output("rerun_mem_en", 32'(mem_en_s[1]), 32'd1);
    check_output("rerun_addr0", 32'(mem_addr_s[1]), 32'd0);
    tick();
    check_output("rerun_addr1", 32'(mem_addr_s[1]), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
